// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Purpose:
//   Collects two 2-bit operands and a 3-bit opcode from slide switches, one
//   value per press of the ENTER button, and presents them as registered
//   operands to a downstream ALU. The CLEAR button abandons the sequence and
//   zeroes the operands. Both buttons are synchronised, debounced and turned
//   into single-cycle rising-edge events before they reach the sequencer FSM.
//
// Ports:
//   clock      in   1  rising-edge system clock
//   reset      in   1  synchronous active-high reset
//   sw         in   3  slide switches; sw[1:0] operand, sw[2:0] opcode
//   btn_enter  in   1  raw asynchronous ENTER button, high when pressed
//   btn_clear  in   1  raw asynchronous CLEAR button, high when pressed
//   A          out  2  registered operand A
//   B          out  2  registered operand B
//   Control    out  3  registered opcode
//   op_valid   out  1  one-cycle pulse on the first cycle in SHOW
//   stage      out  2  current state (00 GET_A, 01 GET_B, 10 GET_OP, 11 SHOW)
//   op_count   out  8  modulo-256 count of committed operations
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [2:0] Control,
  output logic       op_valid,
  output logic [1:0] stage,
  output logic [7:0] op_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic [1:0] {
    GET_A  = 2'b00,
    GET_B  = 2'b01,
    GET_OP = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-FF synchroniser, debounce counter, edge event
  // ---------------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [1:0]       deb_prev_q;
  logic [1:0]       ev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign btn_raw = {btn_clear, btn_enter};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b] = deb_q[b];
      cnt_d[b] = cnt_q[b];
      if (sync2_q[b] == deb_q[b]) begin
        // Any agreement restarts the stability window.
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        deb_d[b] = sync2_q[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      ev_q       <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      // Registered rising-edge detect: only presses produce events, and a
      // held level yields exactly one.
      ev_q       <= deb_q & ~deb_prev_q;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  logic enter_ev;
  logic clear_ev;

  assign enter_ev = ev_q[BTN_ENTER];
  assign clear_ev = ev_q[BTN_CLEAR];

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= GET_A;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next-state logic (clear outranks enter)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = GET_A;
    end else if (enter_ev) begin
      case (state_q)
        GET_A:   state_d = GET_B;
        GET_B:   state_d = GET_OP;
        GET_OP:  state_d = SHOW;
        SHOW:    state_d = GET_A;
        default: state_d = GET_A;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  logic [1:0] a_q, a_d;
  logic [1:0] b_q, b_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic       op_valid_q, op_valid_d;
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    op_count_d = op_count_q;
    // op_valid is high only in the cycle right after the GET_OP commit.
    op_valid_d = 1'b0;
    if (clear_ev) begin
      a_d    = '0;
      b_d    = '0;
      ctrl_d = '0;
    end else if (enter_ev) begin
      // Switches are only looked at here, in the capture cycle.
      case (state_q)
        GET_A:  a_d = sw[1:0];
        GET_B:  b_d = sw[1:0];
        GET_OP: begin
          ctrl_d     = sw;
          op_valid_d = 1'b1;
          op_count_d = op_count_q + 8'd1;  // wraps 255 -> 0
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      op_valid_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      op_valid_q <= op_valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Control  = ctrl_q;
  assign op_valid = op_valid_q;
  assign op_count = op_count_q;
  assign stage    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES = 4. Inputs are
// driven on the falling clock edge; outputs are sampled on the falling edge or
// 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [1:0] A;
  logic [1:0] B;
  logic [2:0] Control;
  logic       op_valid;
  logic [1:0] stage;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int ov_cnt   = 0;
  int ov_base  = 0;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .A         (A),
    .B         (B),
    .Control   (Control),
    .op_valid  (op_valid),
    .stage     (stage),
    .op_count  (op_count)
  );

  always #5 clock = ~clock;

  // Counts cycles with op_valid high.
  always @(negedge clock) begin
    if (op_valid === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic [2:0] ec, input logic ev, input logic [1:0] es,
                           input logic [7:0] en);
    check({tag, ".A"},        32'(A),        32'(ea));
    check({tag, ".B"},        32'(B),        32'(eb));
    check({tag, ".Control"},  32'(Control),  32'(ec));
    check({tag, ".op_valid"}, 32'(op_valid), 32'(ev));
    check({tag, ".stage"},    32'(stage),    32'(es));
    check({tag, ".op_count"}, 32'(op_count), 32'(en));
  endtask

  // Press for 9 cycles (event lands at cycle 7), then release long enough for
  // the debounced level to fall again.
  task automatic press(input logic e, input logic c);
    @(negedge clock);
    btn_enter = e;
    btn_clear = c;
    repeat (9) @(negedge clock);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (9) @(negedge clock);
  endtask

  task automatic enter_with(input logic [2:0] v);
    sw = v;
    press(1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    sw        = 3'b000;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all("reset", 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 8'd0);

    // Event latency: first sampling edge is edge 0, event seen by FSM at edge 7.
    sw = 3'b101;
    @(negedge clock);
    btn_enter = 1'b1;
    repeat (7) @(posedge clock);
    #1 check("lat_before", 32'(stage), 32'd0);
    @(posedge clock);
    #1 check("lat_after", 32'(stage), 32'd1);
    check("capA", 32'(A), 32'd1);
    @(negedge clock);
    btn_enter = 1'b0;
    repeat (10) @(negedge clock);

    // Switch change outside a capture has no effect.
    sw = 3'b111;
    repeat (5) @(negedge clock);
    check("sw_idle.A", 32'(A), 32'd1);
    check("sw_idle.stage", 32'(stage), 32'd1);

    ov_base = ov_cnt;
    enter_with(3'b110);
    check("capB.B", 32'(B), 32'd2);
    check("capB.stage", 32'(stage), 32'd2);
    enter_with(3'b010);
    check_all("commit", 2'd1, 2'd2, 3'd2, 1'b0, 2'd3, 8'd1);
    check("commit.ov_cycles", 32'(ov_cnt - ov_base), 32'd1);

    // SHOW -> GET_A keeps operand values.
    enter_with(3'b000);
    check_all("show_exit", 2'd1, 2'd2, 3'd2, 1'b0, 2'd0, 8'd1);

    // Bouncy button: 3 high / 2 low never stays stable for 4 cycles.
    sw = 3'b011;
    for (int k = 0; k < 8; k++) begin
      btn_enter = 1'b1;
      repeat (3) @(negedge clock);
      btn_enter = 1'b0;
      repeat (2) @(negedge clock);
    end
    repeat (10) @(negedge clock);
    check("bounce.stage", 32'(stage), 32'd0);
    check("bounce.A", 32'(A), 32'd1);

    // Clear in GET_OP.
    enter_with(3'b011);
    enter_with(3'b001);
    check("pre_clear.stage", 32'(stage), 32'd2);
    check("pre_clear.B", 32'(B), 32'd1);
    press(1'b0, 1'b1);
    check_all("clear", 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 8'd1);

    // Enter and clear together in GET_OP: clear wins.
    enter_with(3'b010);
    enter_with(3'b011);
    sw = 3'b111;
    ov_base = ov_cnt;
    press(1'b1, 1'b1);
    check_all("both", 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 8'd1);
    check("both.ov_cycles", 32'(ov_cnt - ov_base), 32'd0);

    // Reset in GET_B.
    enter_with(3'b010);
    check("pre_rst.stage", 32'(stage), 32'd1);
    check("pre_rst.A", 32'(A), 32'd2);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_all("mid_rst", 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 8'd0);

    // Button held through reset release: one event at the normal latency.
    reset     = 1'b1;
    btn_enter = 1'b1;
    sw        = 3'b011;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (7) @(posedge clock);
    #1 check("held_rst.before", 32'(stage), 32'd0);
    @(posedge clock);
    #1 check("held_rst.after", 32'(stage), 32'd1);
    check("held_rst.A", 32'(A), 32'd3);
    repeat (30) @(negedge clock);
    check("held_rst.once", 32'(stage), 32'd1);
    btn_enter = 1'b0;
    repeat (10) @(negedge clock);
    press(1'b0, 1'b1);
    check("held_rst.cleared", 32'(stage), 32'd0);

    // 256 full sequences wrap op_count back to 0.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      enter_with(iv[2:0]);
      enter_with(iv[3:1]);
      enter_with(iv[4:2]);
      enter_with(3'b000);
      if (i == 254) check("wrap.255", 32'(op_count), 32'd255);
    end
    check("wrap.0", 32'(op_count), 32'd0);
    check("wrap.stage", 32'(stage), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, ports named clock and reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, SHALL be the number of consecutive stable clock cycles required to accept a button level change; legal range 2 to 2^24.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 sw  input  3  raw slide switches; sw[1:0] is the operand value and sw[2:0] is the opcode value.
REQ-006 btn_enter  input  1  raw asynchronous push button, high when pressed.
REQ-007 btn_clear  input  1  raw asynchronous push button, high when pressed.
REQ-008 A  output  2  registered operand A, wired directly to the ALU A input.
REQ-009 B  output  2  registered operand B, wired directly to the ALU B input.
REQ-010 Control  output  3  registered opcode, wired directly to the ALU Control input.
REQ-011 op_valid  output  1  one-cycle pulse indicating that a complete operand set has just been committed.
REQ-012 stage  output  2  current state: 00 = GET_A, 01 = GET_B, 10 = GET_OP, 11 = SHOW.
REQ-013 op_count  output  8  count of committed operations.

Function
REQ-014 Button conditioning: each button SHALL pass through a 2-FF synchronizer.
- The block keeps a debounced level per button.
- The debounced level SHALL flip only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- The per-button counter SHALL return to 0 whenever the synchronized level equals the debounced level.
REQ-015 Event generation: a rising edge of the debounced level SHALL produce a one-cycle event (enter_ev or clear_ev). Falling edges SHALL produce no event.
REQ-016 Event latency: an event SHALL be asserted exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first clock edge that samples a stable high raw level.
REQ-017 A level held continuously SHALL produce exactly one event.
REQ-018 In GET_A, on enter_ev: A <= sw[1:0], then go to GET_B.
REQ-019 In GET_B, on enter_ev: B <= sw[1:0], then go to GET_OP.
REQ-020 In GET_OP, on enter_ev: Control <= sw[2:0], op_count increments, then go to SHOW.
- op_valid SHALL be high in the first cycle in SHOW only.
REQ-021 In SHOW, on enter_ev: go to GET_A. A, B and Control SHALL keep their values until overwritten by later captures.
REQ-022 clear_ev in any state SHALL force the following on the next edge:
- state to GET_A;
- A, B and Control to 0;
- op_valid to 0.
op_count SHALL be unchanged.
REQ-023 If clear_ev and enter_ev occur in the same cycle, clear SHALL take priority; no capture and no op_valid.
REQ-024 Switch inputs SHALL be sampled only in the capture cycle. A sw change at any other time SHALL have no effect on the outputs.
REQ-025 op_count SHALL be 8-bit modulo: 255 + 1 = 0, with no flag.
REQ-026 All outputs SHALL be registered. The downstream ALU result SHALL be valid one cycle after op_valid.
REQ-027 stage SHALL reflect the current state register with zero latency.

Reset
REQ-028 While reset is high on a rising edge, the block SHALL set:
- state to GET_A and stage to 00;
- A, B, Control, op_valid and op_count to 0;
- synchronizers, debounced levels and debounce counters to 0.
REQ-029 Reset asserted mid-sequence SHALL discard partial captures; the sequence restarts at GET_A.
REQ-030 A button held through reset release SHALL produce exactly one event, at the latency given in REQ-016 counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Reset pulse -> A=00, B=00, Control=000, op_valid=0, stage=00, op_count=0.
REQ-032 Sequence sw=x01 + enter, then sw=x10 + enter, then sw=010 + enter -> A=01, B=10, Control=010, op_valid high for exactly 1 cycle, stage=11, op_count=1.
REQ-033 btn_enter toggled as high 3 cycles / low 2 cycles for 40 cycles -> no event; stage stays 00; A unchanged.
REQ-034 After A and B are captured (stage=10), a clear press -> A=00, B=00, Control=000, stage=00, op_count unchanged.
REQ-035 In GET_OP, enter and clear pressed in the same cycle so both events coincide -> stage=00, no op_valid, Control=000.
REQ-036 256 complete sequences -> op_count returns to 0.
REQ-037 Reset asserted while stage=01 -> stage=00, all outputs are reset values.
